// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared types and constants for the square-root controller
package sqrt_pkg;

    // Default radicand width and the matching number of root-bit iterations
    localparam int N_BITS_DEF = 16;
    localparam int ITER       = N_BITS_DEF / 2;

    // Controller states, plain binary encoding
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        TEST  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Bundle of every controller output, kept together so they register as one
    typedef struct packed {
        logic rst_ld;
        logic shift;
        logic lda2;
        logic clr_q;
        logic q_sh;
        logic q_bit;
        logic busy;
        logic done;
    } ctrl_t;

    // Moore decode: outputs depend only on the state and the latched compare bit
    function automatic ctrl_t decode_outputs(input state_t s, input logic ge_latched);
        ctrl_t c;
        c = '0;
        case (s)
            LOAD: begin
                c.rst_ld = 1'b1;
                c.clr_q  = 1'b1;
                c.busy   = 1'b1;
            end
            SHIFT: begin
                c.shift = 1'b1;
                c.busy  = 1'b1;
            end
            TEST: begin
                c.busy = 1'b1;
            end
            WRITE: begin
                c.q_sh  = 1'b1;
                c.q_bit = ge_latched;
                c.lda2  = ge_latched;
                c.busy  = 1'b1;
            end
            DONE: begin
                c.done = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sqrt_ctrl.sv
// rtl/sqrt_ctrl.sv - sequencing FSM for the restoring square-root datapath
module sqrt_ctrl
    import sqrt_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic ge,
    output logic rst_ld,
    output logic shift,
    output logic lda2,
    output logic clr_q,
    output logic q_sh,
    output logic q_bit,
    output logic busy,
    output logic done
);

    localparam int ITERS = N_BITS / 2;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    generate
        if ((N_BITS % 2) != 0 || N_BITS < 4) begin : g_bad_width
            $error("sqrt_ctrl: N_BITS must be even and at least 4");
        end
    endgenerate

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             ge_r;
    logic             ge_nx;
    ctrl_t            outs_r;

    // Next-state, iteration counter and compare-latch logic
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ge_nx    = ge_r;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                cnt_nx   = '0;
                state_nx = SHIFT;
            end
            SHIFT: begin
                state_nx = TEST;
            end
            TEST: begin
                // comparator has had the whole TEST cycle to settle after the shift
                ge_nx    = ge;
                state_nx = WRITE;
            end
            WRITE: begin
                if (cnt == CNT_LAST) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx   = cnt + 1'b1;
                    state_nx = SHIFT;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State registers; outputs are registered from the decode of the state being
    // entered, so they present exactly the Moore decode of the current state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            ge_r   <= 1'b0;
            outs_r <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            ge_r   <= ge_nx;
            outs_r <= decode_outputs(state_nx, ge_nx);
        end
    end

    assign rst_ld = outs_r.rst_ld;
    assign shift  = outs_r.shift;
    assign lda2   = outs_r.lda2;
    assign clr_q  = outs_r.clr_q;
    assign q_sh   = outs_r.q_sh;
    assign q_bit  = outs_r.q_bit;
    assign busy   = outs_r.busy;
    assign done   = outs_r.done;

endmodule

// File: doc/sqrt_ctrl.md
# sqrt_ctrl

Sequencing FSM for the restoring square-root datapath of the calculator's square-root unit. It drives the 2-bit remainder/radicand shift register (load, shift, partial-remainder load), the root-bit shift register and the comparator flag, one root bit per iteration. For an N_BITS radicand it runs N_BITS/2 iterations. A start/busy/done handshake faces the calculator's top-level operation sequencer.

## Interface
- N_BITS, default 16: radicand width; must be even and ≥ 4. Iterations: N_BITS/2.
- clk  in  1  system clock; all controller state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request an operation; sampled only in IDLE.
- ge  in  1  datapath comparator flag: partial remainder ≥ trial value (4·Q + 1).
- rst_ld  out  1  load radicand into shift register; clear remainder half.
- shift  out  1  shift remainder/radicand register left by 2.
- lda2  out  1  load (remainder − trial) into the remainder half.
- clr_q  out  1  clear root register.
- q_sh  out  1  shift root register left by 1, inserting q_bit.
- q_bit  out  1  root bit to insert when q_sh = 1.
- busy  out  1  high from LOAD through WRITE of the last iteration.
- done  out  1  one-cycle pulse; root and remainder are valid in the datapath.

## Operation
- States: IDLE, LOAD, SHIFT, TEST, WRITE, DONE.
- IDLE: all outputs 0. If start = 1, go to LOAD.
- LOAD: rst_ld = 1, clr_q = 1, iteration counter ← 0. Go to SHIFT.
- SHIFT: shift = 1. Go to TEST.
- TEST: no datapath strobes; ge_r ← ge, registered at the end of the cycle. Go to WRITE.
- WRITE: q_sh = 1, q_bit = ge_r, lda2 = ge_r.
  - If counter = N_BITS/2 − 1, go to DONE.
  - Otherwise increment the counter and go to SHIFT.
- DONE: done = 1. Go to IDLE unconditionally.
- All outputs are decoded from state and ge_r only (Moore). Outputs never depend combinationally on start or ge.
- Counter width: $clog2(N_BITS/2). It never wraps, because exit happens at N_BITS/2 − 1.
- start in any state other than IDLE is ignored. It is not queued.
- start held high continuously gives back-to-back operations: DONE → IDLE → LOAD, with one IDLE cycle between operations.
- At most one of rst_ld, shift, lda2 is high in any cycle.

## Timing
- Reset (rst_n = 0 at a posedge): state ← IDLE, counter ← 0, ge_r ← 0. Every output is 0 from the following cycle.
- Reset mid-operation aborts immediately. Datapath contents are undefined afterwards; the next start reloads them.
- Controller outputs change on posedge. The datapath register samples on negedge, so strobes are stable half a cycle before use.
- The comparator has a full TEST cycle to settle after the shift.
- Latency, with start sampled in IDLE at edge 0:
  - LOAD is cycle 1.
  - Iteration i occupies cycles 2+3i (SHIFT), 3+3i (TEST) and 4+3i (WRITE).
  - DONE is cycle 2+3·N_BITS/2, which is cycle 26 for N_BITS = 16.
  - IDLE follows one cycle later.
- busy = 1 for cycles 1 through 1+3·N_BITS/2. busy = 0 in DONE and in IDLE.
- Per operation: exactly N_BITS/2 shift pulses and N_BITS/2 q_sh pulses. The number of lda2 pulses equals the popcount of the root.

## Structure
- Shared package sqrt_pkg holds:
  - the state enum (IDLE, LOAD, SHIFT, TEST, WRITE, DONE), binary encoding;
  - the default N_BITS = 16;
  - the ITER = N_BITS/2 constant.
- No sub-module is needed. The counter and FSM live in one module, with a separate next-state block and output decode.
- The top-level sqrt unit instantiates sqrt_ctrl alongside the shift register, the root register, the subtractor and the comparator.

## Test plan
The bench uses a behavioural datapath model on negedge.
- Radicand 0x0051 (81), start pulse:
  - done at cycle 26;
  - root = 9, remainder = 0;
  - 8 shift pulses, 2 lda2 pulses.
- Radicand 0xFFFF:
  - root = 255, remainder = 510;
  - 8 lda2 pulses;
  - q_bit = 1 on every WRITE.
- Radicand 0x0000:
  - root = 0, remainder = 0;
  - 0 lda2 pulses;
  - done still at cycle 26.
- start held high for 60 cycles with radicand 0x0064 (100):
  - two complete operations, each with root = 10;
  - one IDLE cycle between them;
  - start during busy has no effect on the cycle count.
- rst_n = 0 for one cycle during a TEST state of iteration 3:
  - next cycle state = IDLE and all outputs = 0;
  - a new start with radicand 0x0090 (144) yields root = 12 at done.
- Throughout every test, assert that rst_ld, shift and lda2 are one-hot-or-zero, and that done is never high in two consecutive cycles.
